// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider arithmetic,
// configuration legality check and the 3-sample majority voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Clocks per oversample tick.
  function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  // True when the parameter set describes a buildable receiver/transmitter.
  function automatic bit cfg_ok(input int div, input int oversample, input int data_bits,
                                input int stop_bits, input int sync_stages);
    return (div >= 2) && (oversample >= 4) && ((oversample % 2) == 0) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           ((stop_bits == 1) || (stop_bits == 2)) && (sync_stages >= 2);
  endfunction

  // Majority of three samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, with a
// synchronous clear so the tick phase can be aligned to a frame start.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted from zero by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: input synchroniser, 3-sample majority vote,
// configurable frame format, break/framing/parity detection and a
// valid/ready output register with overrun reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  if (!cfg_ok(TICK_DIV, OVERSAMPLE, DATA_BITS, STOP_BITS, SYNC_STAGES)) begin : g_cfg_err
    $error("uart_rx_os: illegal parameter set (TICK_DIV must be >= 2)");
  end

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sample, sample_prev;
  logic                   tick, start_edge, tick_run, at_dec, at_last, bit_val, state_chg;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   vote0, vote1;
  logic [DATA_BITS-1:0]   shifter;
  logic                   par_bit, any_one, stop_bad, stop_first;
  logic                   frame_end, is_break, any_stop0, par_mis, good;

  // Metastability synchroniser and one-sample history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync        <= '1;
      sample_prev <= 1'b1;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], rx_serial};
      sample_prev <= sample;
    end
  end

  assign sample     = sync[SYNC_STAGES-1];
  assign start_edge = (state == IDLE) && !sample && sample_prev;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (start_edge),
    .tick  (tick)
  );

  assign tick_run  = tick && (state != IDLE);
  assign at_dec    = tick_run && (tick_cnt == T_DEC);
  assign at_last   = tick_run && (tick_cnt == T_LAST);
  assign bit_val   = majority3(vote0, vote1, sample);
  assign state_chg = (next_state != state);
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the frame ends at the last stop bit's decision tick.
  always_comb begin
    next_state = state;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) next_state = START;
        else            next_state = IDLE;
      end
      START: begin
        if (at_dec && bit_val) next_state = IDLE;
        else if (at_last)      next_state = DATA;
        else                   next_state = START;
      end
      DATA: begin
        if (at_last && (bit_cnt == B_LAST)) next_state = PAR_EN ? PARITY : STOP;
        else                                next_state = DATA;
      end
      PARITY: begin
        if (at_last) next_state = STOP;
        else         next_state = PARITY;
      end
      STOP: begin
        if (at_dec && (bit_cnt == S_LAST)) begin
          next_state = IDLE;
          frame_end  = 1'b1;
        end else begin
          next_state = STOP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit timing counters, vote samples and frame accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      vote0      <= 1'b1;
      vote1      <= 1'b1;
      shifter    <= '0;
      par_bit    <= 1'b0;
      any_one    <= 1'b0;
      stop_bad   <= 1'b0;
      stop_first <= 1'b1;
    end else begin
      if (state_chg) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (at_last) begin
        tick_cnt <= '0;
        bit_cnt  <= bit_cnt + BW'(1);
      end else if (tick_run) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (tick_run && (tick_cnt == T_S0)) vote0 <= sample;
      if (tick_run && (tick_cnt == T_S1)) vote1 <= sample;
      if (start_edge) begin
        any_one  <= 1'b0;
        stop_bad <= 1'b0;
      end else if (at_dec) begin
        case (state)
          DATA: begin
            shifter <= {bit_val, shifter[DATA_BITS-1:1]};
            any_one <= any_one | bit_val;
          end
          PARITY: begin
            par_bit <= bit_val;
            any_one <= any_one | bit_val;
          end
          STOP: begin
            if (bit_cnt == '0) stop_first <= bit_val;
            stop_bad <= stop_bad | !bit_val;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame classification at the final decision (priority: break, stop, parity).
  assign is_break  = !any_one && !((bit_cnt == '0) ? bit_val : stop_first);
  assign any_stop0 = stop_bad | !bit_val;
  assign par_mis   = PAR_EN && (par_bit != ((^shifter) ^ PAR_ODD));
  assign good      = frame_end && !is_break && !any_stop0 && !par_mis;

  // Output register and one-clock status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      break_det   <= frame_end && is_break;
      frame_err   <= frame_end && !is_break && any_stop0;
      parity_err  <= frame_end && !is_break && !any_stop0 && par_mis;
      overrun_err <= good && rx_valid && !rx_ready;
      if (good && (!rx_valid || rx_ready)) begin
        rx_data  <= shifter;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: two instances (8N1 and 7 data/even parity/2 stop),
// a frame-level expectation queue and an output-register model checked
// every cycle, plus directed literal checks.
module tb_uart_rx_os;

  localparam int CLKF = 3_686_400;
  localparam int BAUD = 115200;
  localparam int OS = 16;
  localparam int BIT_CLKS = 32;
  localparam int K_GOOD = 0, K_PAR = 1, K_FRM = 2, K_BRK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] line = 2'b11;
  logic [1:0] ready = 2'b00;
  logic [7:0] data0;
  logic [6:0] data1;
  logic valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, bk0, bk1, busy0, busy1;

  int checks = 0;
  int failures = 0;
  longint cycle = 0;
  int n_load = 0, n_ovr = 0, n_par = 0, n_frm = 0, n_brk = 0;

  typedef struct {
    int          dut;
    int          kind;
    logic [8:0]  data;
    longint      deadline;
  } exp_t;
  exp_t expq[$];

  logic [1:0] mvalid = 2'b00;
  logic [1:0] vprev = 2'b00;
  logic [1:0] rprev = 2'b00;
  logic [8:0] mdata [0:1];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
               .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .rx_serial(line[0]), .rx_data(data0), .rx_valid(valid0),
    .rx_ready(ready[0]), .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0),
    .break_det(bk0), .busy(busy0));

  uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
               .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .rx_serial(line[1]), .rx_data(data1), .rx_valid(valid1),
    .rx_ready(ready[1]), .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1),
    .break_det(bk1), .busy(busy1));

  function automatic int nbits(input int d);
    return (d == 0) ? 8 : 7;
  endfunction

  // Frame outcome from the line contents, by the protocol's priority rules.
  function automatic int classify(input int d, input logic [8:0] m, input logic par,
                                  input logic [1:0] stops);
    bit pen = (d == 1);
    bit stop_any0 = !stops[0] || ((d == 1) && !stops[1]);
    if ((m == 9'd0) && (!pen || !par) && !stops[0]) return K_BRK;
    if (stop_any0) return K_FRM;
    if (pen && (par != ^m)) return K_PAR;
    return K_GOOD;
  endfunction

  task automatic expect1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input int d, input logic v, input bit glitch);
    for (int c = 0; c < BIT_CLKS; c++) begin
      line[d] = (glitch && (c == 17 || c == 18)) ? 1'b0 : v;
      clks(1);
    end
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input logic par,
                            input logic [1:0] stops, input int gl);
    int nb = nbits(d);
    int ns = (d == 1) ? 2 : 1;
    int tot = 1 + nb + ((d == 1) ? 1 : 0) + ns;
    logic [8:0] m = data & ((9'd1 << nb) - 9'd1);
    expq.push_back('{dut: d, kind: classify(d, m, par, stops), data: m,
                     deadline: cycle + longint'(tot * BIT_CLKS + 64)});
    drive_bit(d, 1'b0, gl == 0);
    for (int i = 0; i < nb; i++) drive_bit(d, m[i], gl == i + 1);
    if (d == 1) drive_bit(d, par, 1'b0);
    for (int s = 0; s < ns; s++) drive_bit(d, stops[s], 1'b0);
    drive_bit(d, 1'b1, 1'b0);
    drive_bit(d, 1'b1, 1'b0);
  endtask

  // Per-cycle comparison of one instance against the expectation queue and register model.
  task automatic check_dut(input int d, input logic v, input logic [8:0] dat,
                           input logic pe, input logic fe, input logic ov, input logic bk);
    logic load;
    int kind;
    bit seen;
    logic exp_ov;
    load = v && (!vprev[d] || rprev[d]);
    seen = 1'b1;
    kind = K_GOOD;
    if (int'(load) + int'(ov) + int'(pe) + int'(fe) + int'(bk) > 1) begin
      checks++;
      failures++;
      $display("FAIL multi_event dut=%0d actual load=%b ovr=%b par=%b frm=%b brk=%b required at most one",
               d, load, ov, pe, fe, bk);
    end
    if (load || ov) kind = K_GOOD;
    else if (pe) kind = K_PAR;
    else if (fe) kind = K_FRM;
    else if (bk) kind = K_BRK;
    else seen = 1'b0;
    if (load) n_load++;
    if (ov) n_ovr++;
    if (pe) n_par++;
    if (fe) n_frm++;
    if (bk) n_brk++;
    if (seen) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event dut=%0d actual kind=%0d required none", d, kind);
      end else if (expq[0].dut != d || expq[0].kind != kind) begin
        failures++;
        $display("FAIL event_kind dut=%0d actual kind=%0d required dut=%0d kind=%0d",
                 d, kind, expq[0].dut, expq[0].kind);
        void'(expq.pop_front());
      end else begin
        if (kind == K_GOOD) begin
          exp_ov = mvalid[d] && !rprev[d];
          checks++;
          if (ov !== exp_ov) begin
            failures++;
            $display("FAIL overrun_vs_load dut=%0d actual ovr=%b required ovr=%b", d, ov, exp_ov);
          end
          if (load) mdata[d] = expq[0].data;
        end
        void'(expq.pop_front());
      end
    end
    if (load) mvalid[d] = 1'b1;
    else if (mvalid[d] && rprev[d]) mvalid[d] = 1'b0;
    checks++;
    if (v !== mvalid[d]) begin
      failures++;
      $display("FAIL rx_valid dut=%0d actual=%b required=%b", d, v, mvalid[d]);
    end
    if (mvalid[d]) begin
      checks++;
      if (dat !== mdata[d]) begin
        failures++;
        $display("FAIL rx_data dut=%0d actual=%0h required=%0h", d, dat, mdata[d]);
      end
    end
    vprev[d] = v;
    rprev[d] = ready[d];
  endtask

  // Compare process, sampling on the falling edge.
  initial begin
    mdata[0] = 9'd0;
    mdata[1] = 9'd0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        expq.delete();
        mvalid = 2'b00;
        vprev = 2'b00;
        rprev = ready;
      end else begin
        check_dut(0, valid0, {1'b0, data0}, pe0, fe0, ov0, bk0);
        check_dut(1, valid1, {2'b00, data1}, pe1, fe1, ov1, bk1);
        if (expq.size() > 0 && expq[0].deadline < cycle) begin
          checks++;
          failures++;
          $display("FAIL event_timeout dut=%0d actual none required kind=%0d",
                   expq[0].dut, expq[0].kind);
          void'(expq.pop_front());
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int l0, o0;
    @(posedge clk);
    #2;
    clks(3);
    expect1("reset_outputs_dut0", {data0, valid0, fe0, pe0, ov0, bk0, busy0}, 32'd0);
    expect1("reset_outputs_dut1", {data1, valid1, fe1, pe1, ov1, bk1, busy1}, 32'd0);
    rst = 1'b0;
    clks(40);

    // 8N1 0xA5 with consumer ready.
    ready = 2'b11;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
    expect1("a5_data", data0, 32'hA5);
    expect1("a5_loads", n_load, 32'd1);
    expect1("a5_no_errors", n_ovr + n_par + n_frm + n_brk, 32'd0);

    // 7E2: wrong then correct parity on 0x41.
    send_frame(1, 9'h041, 1'b1, 2'b11, -1);
    expect1("par_err_count", n_par, 32'd1);
    expect1("par_err_no_valid", valid1, 32'd0);
    send_frame(1, 9'h041, 1'b0, 2'b11, -1);
    expect1("par_ok_data", data1, 32'h41);

    // Glitch inside a data bit, then a short low pulse while idle.
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 4);
    expect1("glitch_data", data0, 32'hFF);
    l0 = n_load;
    line[0] = 1'b0;
    clks(6);
    expect1("false_start_busy", busy0, 32'd1);
    clks(4);
    line[0] = 1'b1;
    clks(20);
    expect1("false_start_idle", busy0, 32'd0);
    clks(64);
    expect1("false_start_no_load", n_load, l0);
    expect1("false_start_data", data0, 32'hFF);

    // Break: line low for 12 bit times; no restart until a fresh edge.
    expq.push_back('{dut: 0, kind: K_BRK, data: 9'd0, deadline: cycle + longint'(12 * BIT_CLKS + 64)});
    line[0] = 1'b0;
    clks(12 * BIT_CLKS);
    expect1("break_count", n_brk, 32'd1);
    expect1("break_held_idle", busy0, 32'd0);
    expect1("break_no_load", n_load, l0);
    line[0] = 1'b1;
    clks(2 * BIT_CLKS);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
    expect1("after_break_data", data0, 32'h5A);

    // Stop bit 0 with nonzero data.
    send_frame(0, 9'h03C, 1'b0, 2'b10, -1);
    expect1("frame_err_count", n_frm, 32'd1);
    expect1("frame_err_break_count", n_brk, 32'd1);

    // Overrun, then acceptance coinciding with a new load.
    ready[0] = 1'b0;
    o0 = n_ovr;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1);
    expect1("overrun_kept_data", data0, 32'h11);
    expect1("overrun_count", n_ovr - o0, 32'd1);
    fork
      send_frame(0, 9'h033, 1'b0, 2'b11, -1);
      begin
        clks(310);
        ready[0] = 1'b1;
        clks(1);
        ready[0] = 1'b0;
      end
    join
    expect1("accept_load_data", data0, 32'h33);
    expect1("accept_load_valid", valid0, 32'd1);
    expect1("accept_load_no_overrun", n_ovr - o0, 32'd1);
    ready[0] = 1'b1;
    clks(4);
    expect1("drained_valid", valid0, 32'd0);

    // Reset in the middle of the data bits.
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    clks(10);
    expect1("mid_frame_busy", busy0, 32'd1);
    rst = 1'b1;
    line[0] = 1'b1;
    #1;
    expect1("mid_reset_outputs", {data0, valid0, fe0, pe0, ov0, bk0, busy0}, 32'd0);
    clks(3);
    rst = 1'b0;
    clks(64);
    send_frame(0, 9'h0C3, 1'b0, 2'b11, -1);
    expect1("post_reset_data", data0, 32'hC3);

    clks(100);
    expect1("pending_events", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
